// File: rtl/mont_arbiter_pkg.sv
// Shared RSA datapath types: operand bundle and key word for the Montgomery multiplier.
package RSA_pkg;

   localparam int MOD_WIDTH = 16;

   typedef logic [MOD_WIDTH-1:0] KeyType;

   typedef struct packed {
      KeyType a;
      KeyType b;
      KeyType modulus;
   } MontgomeryIn;

endpackage

// File: rtl/mont_arbiter_tag_fifo.sv
// In-order tag FIFO: remembers which requester owns each operation in flight.
module tag_fifo #(
   parameter int WIDTH = 1,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         din,
   input  logic                     pop,
   output logic [WIDTH-1:0]         front,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (int'(p) == DEPTH - 1) ? '0 : p + 1'b1;
   endfunction

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign front   = mem[rd_ptr];

   // NOTE: storage has no reset; only the pointers and count define which entries are live.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= next_ptr(wr_ptr);
         if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/mont_arbiter.sv
// Round-robin sharing of one Montgomery multiplier among N_REQ requesters,
// with in-order result routing back to the issuing requester.
module mont_arbiter
   import RSA_pkg::*;
#(
   parameter int N_REQ   = 2,
   parameter int MAX_OUT = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [N_REQ-1:0]          i_valid,
   output logic [N_REQ-1:0]          i_ready,
   input  MontgomeryIn [N_REQ-1:0]   i_in,
   output logic                      m_i_valid,
   input  logic                      m_i_ready,
   output MontgomeryIn               m_i_in,
   input  logic                      m_o_valid,
   output logic                      m_o_ready,
   input  KeyType                    m_o_out,
   output logic [N_REQ-1:0]          o_valid,
   input  logic [N_REQ-1:0]          o_ready,
   output KeyType                    o_out
);

   localparam int TAG_W = $clog2(N_REQ);
   localparam int CNT_W = $clog2(MAX_OUT) + 1;

   typedef logic [TAG_W-1:0] MontArbTag;

   MontArbTag        rr_ptr;
   MontArbTag        locked_idx;
   MontArbTag        pick;
   MontArbTag        grant;
   MontArbTag        head;
   logic             lock;
   logic             pick_any;
   logic             req_any;
   logic             can_issue;
   logic             issue;
   logic             pop;
   logic             fifo_empty;
   logic             fifo_full;
   logic [CNT_W-1:0] count;

   // NOTE: every combinational output gets a default first so no latch is inferred.
   always_comb begin
      pick_any = 1'b0;
      pick     = rr_ptr;
      for (int i = 0; i < N_REQ; i++) begin
         if (!pick_any && i_valid[(int'(rr_ptr) + i) % N_REQ]) begin
            pick_any = 1'b1;
            pick     = MontArbTag'((int'(rr_ptr) + i) % N_REQ);
         end
      end
   end

   // A stalled offer stays pinned to its requester so the multiplier sees stable operands.
   assign grant     = lock ? locked_idx : pick;
   assign req_any   = lock ? i_valid[locked_idx] : pick_any;
   assign can_issue = (count < CNT_W'(MAX_OUT));
   assign m_i_valid = rst && can_issue && req_any;
   assign m_i_in    = i_in[grant];
   assign issue     = m_i_valid && m_i_ready;

   always_comb begin
      i_ready = '0;
      if (issue) i_ready[grant] = 1'b1;
   end

   assign m_o_ready = !fifo_empty && o_ready[head];
   assign o_out     = m_o_out;
   assign pop       = m_o_valid && m_o_ready;

   always_comb begin
      o_valid = '0;
      if (m_o_valid && !fifo_empty) o_valid[head] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rr_ptr     <= '0;
         lock       <= 1'b0;
         locked_idx <= '0;
      end else if (issue) begin
         lock   <= 1'b0;
         rr_ptr <= (grant == MontArbTag'(N_REQ - 1)) ? '0 : grant + 1'b1;
      end else if (m_i_valid) begin
         lock       <= 1'b1;
         locked_idx <= grant;
      end
   end

   tag_fifo #(
      .WIDTH (TAG_W),
      .DEPTH (MAX_OUT)
   ) u_tag_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (issue),
      .din   (grant),
      .pop   (pop),
      .front (head),
      .count (count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // A result with nothing in flight, or a requester dropping a pending offer, is a protocol error.
   a_no_orphan_result: assert property (@(posedge clk) disable iff (!rst)
      m_o_valid |-> !fifo_empty);
   a_offer_held: assert property (@(posedge clk) disable iff (!rst)
      lock |-> (m_i_valid && $stable(m_i_in)));

endmodule

// File: tb/tb_mont_arbiter.sv
// Randomized bench for mont_arbiter against a queue-based reference model and a latency-modelled multiplier.
module tb_mont_arbiter;
   import RSA_pkg::*;

   localparam int N_REQ   = 2;
   localparam int MAX_OUT = 4;

   logic                    clk = 1'b0;
   logic                    rst;
   logic [N_REQ-1:0]        i_valid;
   logic [N_REQ-1:0]        i_ready;
   MontgomeryIn [N_REQ-1:0] i_in;
   logic                    m_i_valid;
   logic                    m_i_ready;
   MontgomeryIn             m_i_in;
   logic                    m_o_valid;
   logic                    m_o_ready;
   KeyType                  m_o_out;
   logic [N_REQ-1:0]        o_valid;
   logic [N_REQ-1:0]        o_ready;
   KeyType                  o_out;

   mont_arbiter #(.N_REQ(N_REQ), .MAX_OUT(MAX_OUT)) dut (
      .clk       (clk),
      .rst       (rst),
      .i_valid   (i_valid),
      .i_ready   (i_ready),
      .i_in      (i_in),
      .m_i_valid (m_i_valid),
      .m_i_ready (m_i_ready),
      .m_i_in    (m_i_in),
      .m_o_valid (m_o_valid),
      .m_o_ready (m_o_ready),
      .m_o_out   (m_o_out),
      .o_valid   (o_valid),
      .o_ready   (o_ready),
      .o_out     (o_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      KeyType val;
      int     due;
   } mult_item_t;

   typedef struct {
      int     owner;
      KeyType val;
   } sb_item_t;

   mult_item_t  mq[$];
   sb_item_t    sb[$];
   int          issue_log[$];
   int          resp_log[$];

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          latency = 10;
   bit          mult_en = 1'b1;

   logic [N_REQ-1:0] req_pending = '0;
   logic [N_REQ-1:0] auto_refill = '0;
   MontgomeryIn      req_ops [N_REQ];

   int          model_ptr = 0;
   bit          model_lock = 1'b0;
   int          model_locked = 0;

   logic [N_REQ-1:0] s_i_ready, s_o_valid;
   logic             s_m_i_valid, s_m_o_ready;
   MontgomeryIn      s_m_i_in;
   KeyType           s_o_out;
   int               s_cyc;

   function automatic KeyType modmul(input MontgomeryIn op);
      return KeyType'((longint'(op.a) * longint'(op.b)) % longint'(op.modulus));
   endfunction

   function automatic MontgomeryIn rand_ops();
      MontgomeryIn op;
      op.a       = KeyType'($urandom);
      op.b       = KeyType'($urandom);
      op.modulus = KeyType'($urandom_range(1, 65535));
      return op;
   endfunction

   function automatic logic [N_REQ-1:0] onehot(input int g);
      logic [N_REQ-1:0] v;
      v = '0;
      v[g] = 1'b1;
      return v;
   endfunction

   function automatic int rr_pick(input logic [N_REQ-1:0] v, input int ptr);
      for (int i = 0; i < N_REQ; i++) begin
         if (v[(ptr + i) % N_REQ]) return (ptr + i) % N_REQ;
      end
      return -1;
   endfunction

   task automatic reset_model();
      sb.delete();
      mq.delete();
      model_ptr  = 0;
      model_lock = 1'b0;
   endtask

   // One clock cycle, entered and left just after a falling edge.
   task automatic cycle();
      int               g;
      int               head;
      bit               exp_mv;
      bit               exp_mor;
      logic [N_REQ-1:0] exp_ir;
      logic [N_REQ-1:0] exp_ov;
      sb_item_t         si;
      mult_item_t       mi;
      i_valid = req_pending;
      for (int k = 0; k < N_REQ; k++) i_in[k] = req_ops[k];
      if (mult_en && mq.size() > 0 && cyc >= mq[0].due) begin
         m_o_valid = 1'b1;
         m_o_out   = mq[0].val;
      end else begin
         m_o_valid = 1'b0;
         m_o_out   = KeyType'($urandom);
      end
      #1;
      g      = model_lock ? model_locked : rr_pick(req_pending, model_ptr);
      exp_mv = (sb.size() < MAX_OUT) && (g >= 0);
      if (exp_mv) exp_mv = req_pending[g];
      exp_ir = (exp_mv && m_i_ready) ? onehot(g) : '0;
      checks++;
      if (m_i_valid !== exp_mv) begin
         errors++;
         $display("FAIL m_i_valid cyc=%0d got=%b exp=%b", cyc, m_i_valid, exp_mv);
      end
      checks++;
      if (i_ready !== exp_ir) begin
         errors++;
         $display("FAIL i_ready cyc=%0d got=%b exp=%b", cyc, i_ready, exp_ir);
      end
      if (exp_mv) begin
         checks++;
         if (m_i_in !== req_ops[g]) begin
            errors++;
            $display("FAIL m_i_in cyc=%0d got=%h exp=%h", cyc, m_i_in, req_ops[g]);
         end
      end
      head    = (sb.size() > 0) ? sb[0].owner : -1;
      exp_mor = (head >= 0) && o_ready[head];
      exp_ov  = (head >= 0 && m_o_valid) ? onehot(head) : '0;
      checks++;
      if (m_o_ready !== exp_mor) begin
         errors++;
         $display("FAIL m_o_ready cyc=%0d got=%b exp=%b", cyc, m_o_ready, exp_mor);
      end
      checks++;
      if (o_valid !== exp_ov) begin
         errors++;
         $display("FAIL o_valid cyc=%0d got=%b exp=%b", cyc, o_valid, exp_ov);
      end
      if (m_o_valid && head >= 0) begin
         checks++;
         if (o_out !== sb[0].val) begin
            errors++;
            $display("FAIL o_out cyc=%0d got=%h exp=%h", cyc, o_out, sb[0].val);
         end
      end
      s_i_ready   = i_ready;
      s_o_valid   = o_valid;
      s_m_i_valid = m_i_valid;
      s_m_o_ready = m_o_ready;
      s_m_i_in    = m_i_in;
      s_o_out     = o_out;
      s_cyc       = cyc;
      // Multiplier side reacts to what actually crossed the interface.
      if (m_i_valid && m_i_ready) begin
         mi.val = modmul(m_i_in);
         mi.due = cyc + latency;
         mq.push_back(mi);
      end
      if (m_o_valid && m_o_ready && mq.size() > 0) void'(mq.pop_front());
      // Reference model bookkeeping.
      if (exp_mv && m_i_ready) begin
         si.owner = g;
         si.val   = modmul(req_ops[g]);
         sb.push_back(si);
         issue_log.push_back(g);
         model_ptr  = (g + 1) % N_REQ;
         model_lock = 1'b0;
      end else if (exp_mv) begin
         model_lock   = 1'b1;
         model_locked = g;
      end
      if (m_o_valid && exp_mor) begin
         void'(sb.pop_front());
         resp_log.push_back(head);
      end
      for (int k = 0; k < N_REQ; k++) begin
         if (i_ready[k]) begin
            req_pending[k] = 1'b0;
            if (auto_refill[k]) begin
               req_ops[k]     = rand_ops();
               req_pending[k] = 1'b1;
            end
         end
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
   endtask

   task automatic drain();
      bit done;
      done        = 1'b0;
      auto_refill = '0;
      m_i_ready   = 1'b1;
      o_ready     = '1;
      mult_en     = 1'b1;
      for (int i = 0; i < 200 && !done; i++) begin
         if (req_pending == '0 && sb.size() == 0 && mq.size() == 0) done = 1'b1;
         else cycle();
      end
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL drain_timeout pending=%b outstanding=%0d", req_pending, sb.size());
      end
   endtask

   task automatic test_reset();
      rst         = 1'b0;
      req_pending = '1;
      for (int k = 0; k < N_REQ; k++) req_ops[k] = rand_ops();
      i_valid   = req_pending;
      for (int k = 0; k < N_REQ; k++) i_in[k] = req_ops[k];
      m_i_ready = 1'b1;
      m_o_valid = 1'b1;
      m_o_out   = '0;
      o_ready   = '1;
      #1;
      checks++;
      if ({i_ready, m_i_valid, o_valid, m_o_ready} !== '0) begin
         errors++;
         $display("FAIL reset_outputs got i_ready=%b m_i_valid=%b o_valid=%b m_o_ready=%b exp all 0",
                  i_ready, m_i_valid, o_valid, m_o_ready);
      end
      @(negedge clk);
      @(negedge clk);
      m_o_valid   = 1'b0;
      req_pending = '0;
      i_valid     = '0;
      reset_model();
      rst = 1'b1;
   endtask

   task automatic test_single();
      int  t_issue;
      bit  seen;
      latency         = 10;
      mult_en         = 1'b1;
      m_i_ready       = 1'b1;
      o_ready         = '1;
      req_ops[0].a       = KeyType'(3);
      req_ops[0].b       = KeyType'(5);
      req_ops[0].modulus = KeyType'(7);
      req_pending     = 2'b01;
      cycle();
      checks++;
      if (s_m_i_valid !== 1'b1 || s_i_ready !== 2'b01) begin
         errors++;
         $display("FAIL single_issue got m_i_valid=%b i_ready=%b exp 1/01", s_m_i_valid, s_i_ready);
      end
      t_issue = s_cyc;
      seen    = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         cycle();
         if (s_o_valid != '0) seen = 1'b1;
      end
      checks++;
      if (!seen || (s_cyc - t_issue) != 10 || s_o_valid !== 2'b01 || s_o_out !== KeyType'((3 * 5) % 7)) begin
         errors++;
         $display("FAIL single_result got seen=%b delay=%0d o_valid=%b o_out=%0d exp 1/10/01/%0d",
                  seen, s_cyc - t_issue, s_o_valid, s_o_out, (3 * 5) % 7);
      end
   endtask

   task automatic test_fairness();
      int first_exp;
      drain();
      latency     = 2;
      first_exp   = model_ptr;
      issue_log.delete();
      for (int k = 0; k < N_REQ; k++) req_ops[k] = rand_ops();
      req_pending = '1;
      auto_refill = '1;
      for (int i = 0; i < 30 && issue_log.size() < 8; i++) cycle();
      auto_refill = '0;
      checks++;
      if (issue_log.size() < 8) begin
         errors++;
         $display("FAIL fairness_count got=%0d exp>=8", issue_log.size());
      end else begin
         checks++;
         if (issue_log[0] != first_exp) begin
            errors++;
            $display("FAIL fairness_first got=%0d exp=%0d", issue_log[0], first_exp);
         end
         for (int i = 1; i < 8; i++) begin
            checks++;
            if (issue_log[i] != (issue_log[i-1] + 1) % N_REQ) begin
               errors++;
               $display("FAIL fairness_alt idx=%0d got=%0d exp=%0d", i, issue_log[i], (issue_log[i-1] + 1) % N_REQ);
            end
         end
      end
      drain();
   endtask

   task automatic test_stall_lock();
      MontgomeryIn held;
      latency     = 3;
      req_ops[0]  = rand_ops();
      req_pending = 2'b01;
      for (int i = 0; i < 10 && req_pending[0]; i++) cycle();
      req_ops[0]  = rand_ops();
      held        = req_ops[0];
      req_pending = 2'b01;
      m_i_ready   = 1'b0;
      for (int c = 0; c < 7; c++) begin
         if (c == 2) begin
            req_ops[1]     = rand_ops();
            req_pending[1] = 1'b1;
         end
         if (c == 5) m_i_ready = 1'b1;
         cycle();
         checks++;
         if (c < 5) begin
            if (s_m_i_valid !== 1'b1 || s_m_i_in !== held || s_i_ready !== 2'b00) begin
               errors++;
               $display("FAIL stall_hold c=%0d got m_i_valid=%b m_i_in=%h i_ready=%b exp 1/%h/00",
                        c, s_m_i_valid, s_m_i_in, s_i_ready, held);
            end
         end else if (c == 5) begin
            if (s_i_ready !== 2'b01) begin
               errors++;
               $display("FAIL stall_release got i_ready=%b exp=01", s_i_ready);
            end
         end else begin
            if (s_i_ready !== 2'b10) begin
               errors++;
               $display("FAIL stall_next got i_ready=%b exp=10", s_i_ready);
            end
         end
      end
      drain();
   endtask

   task automatic test_full();
      latency   = 1;
      mult_en   = 1'b0;
      m_i_ready = 1'b1;
      issue_log.delete();
      for (int k = 0; k < N_REQ; k++) req_ops[k] = rand_ops();
      req_pending = '1;
      auto_refill = '1;
      for (int i = 0; i < 8; i++) cycle();
      checks++;
      if (issue_log.size() != MAX_OUT || s_i_ready !== '0 || s_m_i_valid !== 1'b0) begin
         errors++;
         $display("FAIL full_block got issues=%0d i_ready=%b m_i_valid=%b exp %0d/00/0",
                  issue_log.size(), s_i_ready, s_m_i_valid, MAX_OUT);
      end
      mult_en = 1'b1;
      cycle();
      checks++;
      if (s_m_o_ready !== 1'b1 || issue_log.size() != MAX_OUT) begin
         errors++;
         $display("FAIL full_pop got m_o_ready=%b issues=%0d exp 1/%0d", s_m_o_ready, issue_log.size(), MAX_OUT);
      end
      mult_en = 1'b0;
      cycle();
      checks++;
      if (issue_log.size() != MAX_OUT + 1) begin
         errors++;
         $display("FAIL full_refill got issues=%0d exp=%0d", issue_log.size(), MAX_OUT + 1);
      end
      drain();
   endtask

   task automatic test_routing();
      int order [3] = '{1, 0, 1};
      latency = 2;
      mult_en = 1'b1;
      o_ready = 2'b10;
      resp_log.delete();
      for (int j = 0; j < 3; j++) begin
         req_ops[order[j]]     = rand_ops();
         req_pending[order[j]] = 1'b1;
         for (int i = 0; i < 10 && req_pending[order[j]]; i++) cycle();
      end
      for (int i = 0; i < 6; i++) cycle();
      checks++;
      if (resp_log.size() != 1 || s_o_valid !== 2'b01 || s_m_o_ready !== 1'b0) begin
         errors++;
         $display("FAIL routing_stall got delivered=%0d o_valid=%b m_o_ready=%b exp 1/01/0",
                  resp_log.size(), s_o_valid, s_m_o_ready);
      end
      o_ready = '1;
      for (int i = 0; i < 6; i++) cycle();
      checks++;
      if (resp_log.size() != 3) begin
         errors++;
         $display("FAIL routing_count got=%0d exp=3", resp_log.size());
      end else begin
         for (int j = 0; j < 3; j++) begin
            checks++;
            if (resp_log[j] != order[j]) begin
               errors++;
               $display("FAIL routing_owner idx=%0d got=%0d exp=%0d", j, resp_log[j], order[j]);
            end
         end
      end
      drain();
   endtask

   task automatic test_reset_midflight();
      mult_en   = 1'b0;
      m_i_ready = 1'b1;
      issue_log.delete();
      for (int k = 0; k < N_REQ; k++) req_ops[k] = rand_ops();
      req_pending = '1;
      auto_refill = '1;
      for (int i = 0; i < 10 && issue_log.size() < 3; i++) cycle();
      auto_refill = '0;
      req_pending = '1;
      i_valid     = req_pending;
      #2;
      rst       = 1'b0;
      m_o_valid = 1'b1;
      #1;
      checks++;
      if ({i_ready, m_i_valid, o_valid, m_o_ready} !== '0) begin
         errors++;
         $display("FAIL midreset_outputs got i_ready=%b m_i_valid=%b o_valid=%b m_o_ready=%b exp all 0",
                  i_ready, m_i_valid, o_valid, m_o_ready);
      end
      m_o_valid = 1'b0;
      reset_model();
      @(posedge clk);
      @(negedge clk);
      cyc++;
      rst = 1'b1;
      issue_log.delete();
      auto_refill = '1;
      cycle();
      checks++;
      if (s_i_ready !== 2'b01) begin
         errors++;
         $display("FAIL midreset_first got i_ready=%b exp=01", s_i_ready);
      end
      for (int i = 0; i < 6; i++) cycle();
      checks++;
      if (issue_log.size() != MAX_OUT) begin
         errors++;
         $display("FAIL midreset_capacity got issues=%0d exp=%0d", issue_log.size(), MAX_OUT);
      end
      drain();
   endtask

   initial begin
      test_reset();
      test_single();
      test_fairness();
      test_stall_lock();
      test_full();
      test_routing();
      test_reset_midflight();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
